// File: rtl/bidirect_bus_slave_if.sv
// Valid/ready bus between a master and the bidirect_bus_slave responder.
// The master holds valid until it sees the single-cycle ready strobe.
interface bidirect_bus_slave_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        rnw;
  logic        valid;
  logic [3:0]  wait_cycles;
  logic        ready;
  logic [31:0] read_data;
  logic        error;

  modport master (
    output addr, write_data, rnw, valid, wait_cycles,
    input  ready, read_data, error
  );

  modport slave (
    input  addr, write_data, rnw, valid, wait_cycles,
    output ready, read_data, error
  );
endinterface

// File: rtl/bidirect_bus_slave.sv
// Word-addressed register slave: one transfer at a time, ready wait_cycles+1 cycles after acceptance.
// Inputs are ignored outside IDLE; ready/read_data/error are registered and zero outside RESP.
module bidirect_bus_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  bidirect_bus_slave_if.slave  bus,
  output logic [15:0]          txn_count,
  output logic [7:0]           err_count
);
  localparam int unsigned IDXW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] BASE_X = {1'b0, ADDR_BASE};
  localparam logic [32:0] SPAN   = 33'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      wait_cnt;
  logic [3:0]      wait_cnt_nxt;
  logic            accept;
  logic            resp_enter;

  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            rnw_q;

  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic            cur_rnw;
  logic [32:0]     offset;
  logic            cur_err;
  logic [IDXW-1:0] cur_idx;

  logic [15:0]     txn_nxt;
  logic [7:0]      err_nxt;

  logic [31:0]     mem [MEM_DEPTH];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          accept       = 1'b1;
          wait_cnt_nxt = bus.wait_cycles;
          state_nxt    = (bus.wait_cycles != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign resp_enter = (state_nxt == RESP) && (state != RESP);

  // With wait_cycles=0 the transfer resolves on its acceptance edge, so the
  // live bus fields are used in IDLE and the latched copy afterwards.
  always_comb begin
    cur_addr  = (state == IDLE) ? bus.addr       : addr_q;
    cur_wdata = (state == IDLE) ? bus.write_data : wdata_q;
    cur_rnw   = (state == IDLE) ? bus.rnw        : rnw_q;
    // 33-bit offset: a borrow (addr below base) makes it exceed SPAN too.
    offset    = {1'b0, cur_addr} - BASE_X;
    cur_err   = (cur_addr[1:0] != 2'b00) || (offset >= SPAN);
    cur_idx   = offset[IDXW+1:2];
  end

  always_comb begin
    txn_nxt = txn_count;
    err_nxt = err_count;
    if (state == RESP) begin
      txn_nxt = txn_count + 16'd1;
      if (bus.error && (err_count != 8'hFF)) begin
        err_nxt = err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      rnw_q         <= 1'b0;
      bus.ready     <= 1'b0;
      bus.error     <= 1'b0;
      bus.read_data <= 32'd0;
      txn_count     <= 16'd0;
      err_count     <= 8'd0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.write_data;
        rnw_q   <= bus.rnw;
      end
      bus.ready     <= resp_enter;
      bus.error     <= resp_enter && cur_err;
      bus.read_data <= (resp_enter && cur_rnw && !cur_err) ? mem[cur_idx] : 32'd0;
      if (resp_enter && !cur_rnw && !cur_err) begin
        mem[cur_idx] <= cur_wdata;
      end
      txn_count <= txn_nxt;
      err_count <= err_nxt;
    end
  end
endmodule

// File: tb/tb_bidirect_bus_slave.sv
// Directed plus randomized bench for bidirect_bus_slave against a word-array reference model.
module tb_bidirect_bus_slave;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk;
  logic        resetn;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  bidirect_bus_slave_if bus ();

  bidirect_bus_slave #(
    .ADDR_BASE (BASE),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mem_m [DEPTH];
  logic [15:0] txn_m;
  logic [7:0]  err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    longint unsigned ua;
    ua = 64'(a);
    return ((ua % 4) != 0) || (ua < 64'(BASE)) || (ua >= 64'(BASE) + 4 * DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    txn_m = 16'h0;
    err_m = 8'h0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 32'h0);
    chk({tag, "_error"}, 32'(bus.error), 32'h0);
    chk({tag, "_rdata"}, bus.read_data, 32'h0);
    chk({tag, "_txn"}, 32'(txn_count), 32'(txn_m));
    chk({tag, "_errcnt"}, 32'(err_count), 32'(err_m));
  endtask

  // One transfer; returns at the negedge where ready is seen.
  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input bit rd, input logic [3:0] w);
    bit          e;
    int          idx;
    int          cyc;
    logic [31:0] exp_rd;
    e      = exp_err(a);
    idx    = e ? 0 : int'((a - BASE) >> 2);
    exp_rd = (rd && !e) ? mem_m[idx] : 32'h0;
    @(negedge clk);
    idle_outputs("idle");
    bus.valid       = 1'b1;
    bus.addr        = a;
    bus.write_data  = wd;
    bus.rnw         = rd;
    bus.wait_cycles = w;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.valid       = 1'b0;
        bus.addr        = $urandom;
        bus.write_data  = $urandom;
        bus.rnw         = 1'($urandom);
        bus.wait_cycles = 4'($urandom);
      end
    end while (!bus.ready && cyc < 40);
    chk("ready_seen", 32'(bus.ready), 32'h1);
    chk("latency", 32'(cyc), 32'(int'(w) + 1));
    chk("error", 32'(bus.error), 32'(e));
    chk("read_data", bus.read_data, exp_rd);
    if (!rd && !e) mem_m[idx] = wd;
    txn_m = txn_m + 16'd1;
    if (e && err_m != 8'hFF) err_m = err_m + 8'd1;
  endtask

  initial begin
    time         t0;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] pat [DEPTH];

    resetn          = 1'b0;
    bus.valid       = 1'b0;
    bus.addr        = 32'h0;
    bus.write_data  = 32'h0;
    bus.rnw         = 1'b0;
    bus.wait_cycles = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    idle_outputs("in_reset");
    resetn = 1'b1;
    @(negedge clk);
    idle_outputs("post_reset");

    // Write then read back, no wait states
    do_xfer(32'h0000_1004, 32'hA5A5_0001, 1'b0, 4'd0);
    do_xfer(32'h0000_1004, 32'h0, 1'b1, 4'd0);
    // Five wait states on an untouched word
    do_xfer(32'h0000_1000, 32'h0, 1'b1, 4'd5);

    // Decode and alignment errors must not disturb stored data
    do_xfer(32'h0000_1000, 32'h1234_5678, 1'b0, 4'd1);
    do_xfer(32'h0000_1002, 32'hDEAD_0001, 1'b0, 4'd0);
    do_xfer(32'h0000_0FFC, 32'hDEAD_0002, 1'b0, 4'd2);
    do_xfer(32'h0000_1040, 32'hDEAD_0003, 1'b0, 4'd0);
    do_xfer(32'h0000_1000, 32'h0, 1'b1, 4'd0);
    @(negedge clk);
    chk("err_count_3", 32'(err_count), 32'h3);

    // Zero-delay back-to-back across every word
    for (int i = 0; i < DEPTH; i++) pat[i] = $urandom;
    t0 = $time;
    for (int i = 0; i < DEPTH; i++) do_xfer(BASE + 32'(4 * i), pat[i], 1'b0, 4'd0);
    for (int i = 0; i < DEPTH; i++) do_xfer(BASE + 32'(4 * i), 32'h0, 1'b1, 4'd0);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd64);

    // Random mix against the model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        1:       a = BASE - 32'(4 * $urandom_range(1, 4));
        2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        3:       a = 32'hFFFF_FFFC;
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      wd = $urandom;
      do_xfer(a, wd, 1'($urandom), 4'($urandom_range(0, 4)));
    end

    // Reset during WAIT of a write: nothing counted, word stays zero
    @(negedge clk);
    bus.valid       = 1'b1;
    bus.addr        = 32'h0000_1008;
    bus.write_data  = 32'hCAFE_F00D;
    bus.rnw         = 1'b0;
    bus.wait_cycles = 4'd3;
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    idle_outputs("abort_wait");
    @(negedge clk);
    resetn = 1'b1;
    do_xfer(32'h0000_1008, 32'h0, 1'b1, 4'd0);

    // Reset during RESP clears a live ready/read_data at once
    do_xfer(32'h0000_1010, 32'h5A5A_5A5A, 1'b0, 4'd0);
    @(negedge clk);
    bus.valid       = 1'b1;
    bus.addr        = 32'h0000_1010;
    bus.rnw         = 1'b1;
    bus.wait_cycles = 4'd0;
    @(negedge clk);
    bus.valid = 1'b0;
    chk("resp_ready", 32'(bus.ready), 32'h1);
    chk("resp_rdata", bus.read_data, 32'h5A5A_5A5A);
    resetn = 1'b0;
    #1;
    model_reset();
    idle_outputs("abort_resp");
    @(negedge clk);
    resetn = 1'b1;

    // Error counter saturation
    for (int n = 0; n < 256; n++) do_xfer(32'h0000_1001, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    chk("err_sat", 32'(err_count), 32'hFF);

    // Transfer counter wrap from 16'hFFFF
    @(negedge clk);
    force dut.txn_count = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count;
    txn_m = 16'hFFFF;
    do_xfer(32'h0000_1000, 32'h0000_0042, 1'b0, 4'd0);
    @(negedge clk);
    idle_outputs("wrap");
    chk("txn_wrap", 32'(txn_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
